// File: rtl/coherence_bus_sequencer_pkg.sv
// Shared definitions for the snooping coherence bus sequencer: bus op
// encodings, FSM state encoding and an op-validity helper.
package coherence_bus_sequencer_pkg;

    typedef enum logic [2:0] {
        BUS_NONE  = 3'd0,
        BUS_RD    = 3'd1,
        BUS_RDX   = 3'd2,
        BUS_UPGR  = 3'd3,
        BUS_FLUSH = 3'd4
    } bus_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNOOP = 3'd1,
        RESP  = 3'd2,
        XFER  = 3'd3,
        MEM   = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Only BusRd, BusRdX, BusUpgr and Flush may take part in arbitration.
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

endpackage

// File: rtl/coherence_bus_sequencer_rr_arbiter.sv
// Round-robin priority picker: rotates the eligibility vector so rr_ptr sits
// at bit 0, isolates the lowest set bit, then rotates the one-hot back.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);

    logic [N-1:0] rot_s;
    logic [N-1:0] rot_oh_s;

    // Rotate, pick lowest, rotate back.
    always_comb begin
        rot_s    = N'({elig, elig} >> ptr);
        rot_oh_s = rot_s & (~rot_s + 1'b1);
        winner   = N'({rot_oh_s, rot_oh_s} << ptr >> N);
        valid    = |elig;
    end

endmodule

// File: rtl/coherence_bus_sequencer.sv
// Snooping bus sequencer: arbitrates cache requests, broadcasts the snoop,
// routes to cache-to-cache transfer or memory, and pulses done to the owner.
module coherence_bus_sequencer
    import coherence_bus_sequencer_pkg::*;
#(
    parameter int NUM_CPUS   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int SNOOP_WAIT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CPUS-1:0]            req,
    input  logic [NUM_CPUS*3-1:0]          req_op,
    input  logic [NUM_CPUS*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_CPUS-1:0]            grant,
    output logic                           snoop_valid,
    output logic [2:0]                     snoop_op,
    output logic [ADDR_WIDTH-1:0]          snoop_addr,
    output logic [$clog2(NUM_CPUS)-1:0]    snoop_src,
    input  logic [NUM_CPUS-1:0]            snoop_hit,
    input  logic [NUM_CPUS-1:0]            snoop_supply,
    output logic [NUM_CPUS-1:0]            supply_sel,
    output logic                           shared,
    output logic                           mem_rd,
    output logic                           mem_wr,
    input  logic                           mem_ready,
    output logic [NUM_CPUS-1:0]            done,
    output logic                           busy
);

    localparam int SRC_W = $clog2(NUM_CPUS);
    localparam int CNT_W = (SNOOP_WAIT > 1) ? $clog2(SNOOP_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SNOOP_WAIT - 1);

    state_e                  state_r, state_nxt_s;
    logic [NUM_CPUS-1:0]     grant_r, hit_r, supply_r;
    logic [2:0]              op_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [SRC_W-1:0]        src_r, rr_ptr_r;
    logic [CNT_W-1:0]        cnt_r;

    logic [NUM_CPUS-1:0]     elig_s, win_oh_s, hit_m_s, sup_m_s;
    logic                    win_vld_s;
    logic [SRC_W-1:0]        win_idx_s;
    logic [2:0]              win_op_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;

    rr_arbiter #(.N(NUM_CPUS), .PW(SRC_W)) u_arb (
        .elig   (elig_s),
        .ptr    (rr_ptr_r),
        .winner (win_oh_s),
        .valid  (win_vld_s)
    );

    // Eligibility and one-hot muxing of the winner's index, op and address.
    always_comb begin
        elig_s     = '0;
        win_idx_s  = '0;
        win_op_s   = 3'd0;
        win_addr_s = '0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            elig_s[i]  = req[i] && op_is_valid(req_op[i*3 +: 3]);
            win_idx_s  = win_idx_s | (win_oh_s[i] ? SRC_W'(i) : '0);
            win_op_s   = win_op_s | ({3{win_oh_s[i]}} & req_op[i*3 +: 3]);
            win_addr_s = win_addr_s |
                         ({ADDR_WIDTH{win_oh_s[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    assign hit_m_s = snoop_hit & ~grant_r;
    assign sup_m_s = snoop_supply & ~grant_r;

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (win_vld_s) begin
                    state_nxt_s = (win_op_s == BUS_FLUSH) ? MEM : SNOOP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SNOOP: state_nxt_s = RESP;
            RESP: begin
                if (cnt_r != CNT_LAST) begin
                    state_nxt_s = RESP;
                end else if (op_r == BUS_UPGR) begin
                    state_nxt_s = DONE;
                end else if (|sup_m_s) begin
                    state_nxt_s = XFER;
                end else begin
                    state_nxt_s = MEM;
                end
            end
            XFER: state_nxt_s = DONE;
            MEM: begin
                if (mem_ready) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = MEM;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Transaction context: winner, latched request, response window, snoop results.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r  <= '0;
            op_r     <= 3'd0;
            addr_r   <= '0;
            src_r    <= '0;
            rr_ptr_r <= '0;
            cnt_r    <= '0;
            hit_r    <= '0;
            supply_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_vld_s) begin
                        grant_r  <= win_oh_s;
                        op_r     <= win_op_s;
                        addr_r   <= win_addr_s;
                        src_r    <= win_idx_s;
                        rr_ptr_r <= (win_idx_s == SRC_W'(NUM_CPUS - 1)) ? '0 : win_idx_s + 1'b1;
                        hit_r    <= '0;
                        supply_r <= '0;
                    end
                end
                SNOOP: cnt_r <= '0;
                RESP: begin
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        hit_r    <= hit_m_s;
                        supply_r <= sup_m_s;
                    end
                end
                DONE:    grant_r <= '0;
                default: cnt_r   <= cnt_r;
            endcase
        end
    end

    // Flush never samples snoop responses, so hit_r stays clear and shared reads 0.
    assign grant       = grant_r;
    assign busy        = (state_r != IDLE);
    assign snoop_valid = (state_r == SNOOP);
    assign snoop_op    = snoop_valid ? op_r : 3'd0;
    assign snoop_addr  = snoop_valid ? addr_r : '0;
    assign snoop_src   = snoop_valid ? src_r : '0;
    assign supply_sel  = (state_r == XFER) ? (supply_r & (~supply_r + 1'b1)) : '0;
    assign mem_rd      = (state_r == MEM) && (op_r != BUS_FLUSH);
    assign mem_wr      = (state_r == MEM) && (op_r == BUS_FLUSH);
    assign done        = (state_r == DONE) ? grant_r : '0;
    assign shared      = (state_r == DONE) && (|hit_r);

endmodule

// File: tb/tb_coherence_bus_sequencer.sv
// Scoreboard bench: stimulus pushes the expected per-transaction record, a
// negedge monitor accumulates bus activity and compares on every done pulse.
module tb_coherence_bus_sequencer;

    logic         clk, rst;
    logic [3:0]   req, grant, snoop_hit, snoop_supply, supply_sel, done;
    logic [11:0]  req_op;
    logic [127:0] req_addr;
    logic         snoop_valid, shared, mem_rd, mem_wr, mem_ready, busy;
    logic [2:0]   snoop_op;
    logic [31:0]  snoop_addr;
    logic [1:0]   snoop_src;

    coherence_bus_sequencer #(.NUM_CPUS(4), .ADDR_WIDTH(32), .SNOOP_WAIT(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
        .grant(grant), .snoop_valid(snoop_valid), .snoop_op(snoop_op),
        .snoop_addr(snoop_addr), .snoop_src(snoop_src), .snoop_hit(snoop_hit),
        .snoop_supply(snoop_supply), .supply_sel(supply_sel), .shared(shared),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready), .done(done),
        .busy(busy)
    );

    typedef struct {
        int         tag;
        logic [3:0] grant;
        logic       shared;
        int         snoops;
        logic [2:0] op;
        logic [31:0] addr;
        logic [1:0] src;
        int         nrd;
        int         nwr;
        logic [3:0] sup;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   mem_lat = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // Memory model: raises mem_ready in the mem_lat-th cycle of a request; 0 = never.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_rd || mem_wr) begin
                cnt++;
                mem_ready = (mem_lat != 0) && (cnt == mem_lat);
            end else begin
                cnt = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // Monitor: tracks one transaction from grant rise to done.
    logic       trk = 1'b0;
    int         m_lat, m_snp, m_rd, m_wr;
    logic [3:0] m_sup;
    logic [2:0] m_op;
    logic [31:0] m_addr;
    logic [1:0] m_src;
    exp_t       e_m;

    always @(negedge clk) begin
        if (rst) begin
            trk = 1'b0;
        end else begin
            if (grant != 4'd0 && !trk) begin
                trk = 1'b1; m_lat = 1; m_snp = 0; m_rd = 0; m_wr = 0;
                m_sup = 4'd0; m_op = 3'd0; m_addr = 32'd0; m_src = 2'd0;
            end else if (trk) begin
                m_lat++;
            end
            if (trk) begin
                if (snoop_valid) begin
                    m_snp++; m_op = snoop_op; m_addr = snoop_addr; m_src = snoop_src;
                end
                if (mem_rd) m_rd++;
                if (mem_wr) m_wr++;
                m_sup = m_sup | supply_sel;
            end
            if (done != 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", {60'd0, done}, 64'd0);
                end else begin
                    e_m = exp_q.pop_front();
                    chk($sformatf("t%0d_done", e_m.tag), {60'd0, done}, {60'd0, e_m.grant});
                    chk($sformatf("t%0d_grant", e_m.tag), {60'd0, grant}, {60'd0, e_m.grant});
                    chk($sformatf("t%0d_shared", e_m.tag), {63'd0, shared}, {63'd0, e_m.shared});
                    chk($sformatf("t%0d_snoop_cnt", e_m.tag), 64'(m_snp), 64'(e_m.snoops));
                    if (e_m.snoops != 0) begin
                        chk($sformatf("t%0d_snoop_op", e_m.tag), {61'd0, m_op}, {61'd0, e_m.op});
                        chk($sformatf("t%0d_snoop_addr", e_m.tag), {32'd0, m_addr}, {32'd0, e_m.addr});
                        chk($sformatf("t%0d_snoop_src", e_m.tag), {62'd0, m_src}, {62'd0, e_m.src});
                    end
                    chk($sformatf("t%0d_mem_rd_cyc", e_m.tag), 64'(m_rd), 64'(e_m.nrd));
                    chk($sformatf("t%0d_mem_wr_cyc", e_m.tag), 64'(m_wr), 64'(e_m.nwr));
                    chk($sformatf("t%0d_supply_sel", e_m.tag), {60'd0, m_sup}, {60'd0, e_m.sup});
                    chk($sformatf("t%0d_latency", e_m.tag), 64'(m_lat), 64'(e_m.lat));
                end
                trk = 1'b0;
            end
        end
    end

    task automatic push_exp(input int tag, input logic [3:0] g, input logic sh, input int snp,
                            input logic [2:0] op, input logic [31:0] addr, input logic [1:0] src,
                            input int nrd, input int nwr, input logic [3:0] sup, input int lat);
        exp_t e;
        e.tag = tag; e.grant = g; e.shared = sh; e.snoops = snp; e.op = op; e.addr = addr;
        e.src = src; e.nrd = nrd; e.nwr = nwr; e.sup = sup; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic set_cpu(input int i, input logic [2:0] op, input logic [31:0] addr);
        req_op[i*3 +: 3]    = op;
        req_addr[i*32 +: 32] = addr;
    endtask

    // Hold requests in mask until each owner sees done, then wait for IDLE.
    task automatic run_quiet(input string nm, input logic [3:0] mask, input int budget);
        int n;
        n = 0;
        while (((req & mask) != 4'd0 || busy) && n < budget) begin
            @(negedge clk);
            req = req & ~done;
            n++;
        end
        chk({nm, "_complete"}, {62'd0, ((req & mask) != 4'd0), busy}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; req = 4'd0; req_op = 12'd0; req_addr = 128'd0;
        snoop_hit = 4'd0; snoop_supply = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {10'd0, grant, done, snoop_valid, snoop_op, snoop_addr, snoop_src,
                              supply_sel, shared, mem_rd, mem_wr, busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // cpu1 BusRd, no hits, memory answers in the 3rd mem_rd cycle.
        mem_lat = 3;
        push_exp(1, 4'b0010, 1'b0, 1, 3'd1, 32'h0000_1040, 2'd1, 3, 0, 4'b0000, 7);
        set_cpu(1, 3'd1, 32'h0000_1040);
        req = 4'b0010;
        run_quiet("t1", 4'b1111, 40);

        // cpu0 BusRdX, cpu2 supplies the dirty line.
        snoop_hit = 4'b0100; snoop_supply = 4'b0100;
        push_exp(2, 4'b0001, 1'b1, 1, 3'd2, 32'h0000_2080, 2'd0, 0, 0, 4'b0100, 5);
        set_cpu(0, 3'd2, 32'h0000_2080);
        req = 4'b0001;
        run_quiet("t2", 4'b1111, 40);

        // All four BusUpgr from reset; cpu0's own hit is masked, its supply ignored.
        do_reset();
        snoop_hit = 4'b0001; snoop_supply = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            set_cpu(i, 3'd3, 32'h0000_3000 + 32'(i) * 32'h100);
            push_exp(3, 4'(1 << i), (i != 0), 1, 3'd3, 32'h0000_3000 + 32'(i) * 32'h100,
                     2'(i), 0, 0, 4'b0000, 4);
        end
        req = 4'b1111;
        run_quiet("t3", 4'b1111, 80);

        // cpu3 Flush: no snoop, mem_wr for 4 cycles, shared stays 0 despite hits.
        snoop_hit = 4'b0011; snoop_supply = 4'b0000; mem_lat = 4;
        push_exp(4, 4'b1000, 1'b0, 0, 3'd4, 32'hFFFF_FFE0, 2'd3, 0, 4, 4'b0000, 5);
        set_cpu(3, 3'd4, 32'hFFFF_FFE0);
        req = 4'b1000;
        run_quiet("t4", 4'b1111, 40);

        // cpu2 BusRd aborted by reset while in MEM.
        snoop_hit = 4'b0000; mem_lat = 0;
        set_cpu(2, 3'd1, 32'h0000_5000);
        req = 4'b0100;
        n = 0;
        while (!mem_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_mem", {63'd0, mem_rd}, 64'd1);
        rst = 1'b1; req = 4'b0000;
        @(negedge clk);
        chk("t5_reset_outputs", {10'd0, grant, done, snoop_valid, snoop_op, snoop_addr, snoop_src,
                                 supply_sel, shared, mem_rd, mem_wr, busy}, 64'd0);
        rst = 1'b0;
        // rr_ptr is back at 0, so cpu1 must beat cpu3.
        set_cpu(1, 3'd3, 32'h0000_6040);
        set_cpu(3, 3'd3, 32'h0000_60C0);
        push_exp(5, 4'b0010, 1'b0, 1, 3'd3, 32'h0000_6040, 2'd1, 0, 0, 4'b0000, 4);
        push_exp(5, 4'b1000, 1'b0, 1, 3'd3, 32'h0000_60C0, 2'd3, 0, 0, 4'b0000, 4);
        req = 4'b1010;
        run_quiet("t5", 4'b1111, 60);

        // cpu0 with op 0 is never eligible; cpu1 BusRd wins from rr_ptr 0.
        mem_lat = 1;
        set_cpu(0, 3'd0, 32'h0000_7000);
        set_cpu(1, 3'd1, 32'h0000_7040);
        push_exp(6, 4'b0010, 1'b0, 1, 3'd1, 32'h0000_7040, 2'd1, 1, 0, 4'b0000, 5);
        req = 4'b0011;
        run_quiet("t6", 4'b0010, 40);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_op0_ignored", {59'd0, grant, busy}, 64'd0);
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);

        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
